rtc_hms_timer: RTL
==================

Name: rtc_hms_timer

Overview:
- Parametrised successor to the seconds/minutes counter block: a real-time clock and timer core producing hours, minutes and seconds.
- Supports count-up (stopwatch/clock) and count-down (timer with done) modes, with start/stop/load control.
- An internal prescaler derives a 1 Hz tick (generalised to TICK_HZ) from the system clock.
- Sits between the board clock domain and display/alarm logic; one clock domain throughout.

Parameters:
- CLK_HZ, 125000000, system clock frequency in Hz.
- TICK_HZ, 1, time-base tick rate. DIV = CLK_HZ/TICK_HZ, which must be an integer ≥ 2.
- MAX_HOURS, 24, hour modulus. Must be ≥ 1.
- HOUR_W, 5, width of hour fields. Must satisfy 2^HOUR_W ≥ MAX_HOURS.

Ports:
- clk_125MHz  in  1  system clock (the name is kept for any CLK_HZ). One clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; run request, sampled every cycle.
- stop  in  1  level; pause request.
- mode  in  1  0 = count up, 1 = count down. Sampled only while not RUN.
- load  in  1  one-cycle load strobe.
- load_hh  in  HOUR_W  hour load value.
- load_mm  in  6  minute load value.
- load_ss  in  6  second load value.
- hh  out  HOUR_W  current hours.
- mm  out  6  current minutes.
- ss  out  6  current seconds.
- tick  out  1  one-cycle pulse on each prescaler terminal count while RUN.
- running  out  1  high in RUN.
- done  out  1  sticky; countdown reached 0:00:00.
- wrap  out  1  one-cycle pulse when count-up rolls MAX_HOURS-1:59:59 to 0:00:00.

Behaviour:
- Reset: all outputs 0, prescaler 0, state IDLE, latched mode 0.
- FSM states are IDLE, RUN, PAUSE, DONE.
  - IDLE/PAUSE → RUN on start=1 and stop=0. Mode is latched on this transition.
  - RUN → PAUSE on stop=1. If start and stop are both high, stop wins in every state.
  - RUN → DONE when count-down mode reaches 0:00:00. done=1 in the same cycle the time becomes zero.
  - DONE → IDLE only on load or rst; start is ignored in DONE.
- Count-down started with time = 0:00:00: the FSM enters DONE on the next cycle, with no tick.
- load (any state, lower priority than rst only):
  - Next state is IDLE; done is cleared and the prescaler is cleared.
  - hh/mm/ss take the load values, saturated to ss,mm ≤ 59 and hh ≤ MAX_HOURS-1.
- Prescaler:
  - Counts 0..DIV-1 only in RUN and holds its value in PAUSE.
  - tick is asserted in the cycle where the prescaler equals DIV-1 while in RUN.
  - The time registers update on that same edge, so the new value is visible in the cycle after tick.
  - First tick comes exactly DIV cycles after entry to RUN from a cleared prescaler.
- Count-up carries: ss 59→0 with mm+1; mm 59→0 with hh+1; hh MAX_HOURS-1→0 with wrap pulsed for one cycle (aligned with the registers updating).
- Count-down borrows: ss 0→59 with mm-1; mm 0→59 with hh-1. Zero detect ends the count.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Reset mid-RUN: reset values are applied on the next edge.

Optional Feature:
- Macro RTC_HMS_ALARM_EN.
- Defined: adds inputs alarm_en (1), alarm_hh (HOUR_W), alarm_mm (6), alarm_ss (6) and output alarm (1).
  - alarm pulses for one cycle when, in RUN, a tick update makes the time equal the alarm value and alarm_en=1.
  - A load that sets a matching value does not fire alarm.
- Undefined: those ports and the logic are absent; all other behaviour is identical.

Decomposition:
- Package rtc_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - constants SEC_MAX=59 and MIN_MAX=59;
  - the function computing DIV and the prescaler width $clog2(DIV).
- One sub-module, rtc_prescaler: enable, clear, DIV parameter, terminal-count pulse output.

Test Plan (CLK_HZ=10, TICK_HZ=1, MAX_HOURS=24 for speed):
- Count-up: rst 2 cycles, start=1, mode=0 → tick every 10 cycles; ss=1 on the cycle after the first tick; after 60 ticks mm=1, ss=0.
- Count-down: load 0:00:03, mode=1, start → done=1 and running=0 after 30 cycles; time holds 0:00:00; start again has no effect; load clears done.
- Pause: run 25 cycles, stop 40 cycles, then start → the ss=3 tick arrives 5 cycles after restart (prescaler held).
- Wrap and saturation:
  - load 23:59:58 and count up → after 2 ticks time is 0:00:00 with wrap pulsed once.
  - load 30:70:70 → 23:59:59.
- Priority: start=stop=1 from IDLE → stays IDLE. rst asserted mid-RUN at 5:06:07 → all zero next cycle, IDLE.
- Count-down from zero: load 0:00:00, mode=1, start → DONE one cycle later, tick never asserted.
- With RTC_HMS_ALARM_EN: alarm 0:00:05, count up from 0 → single alarm pulse at the ss=5 update.

Source files
------------

// File: rtl/rtc_hms_timer_pkg.sv
// Shared types and constants for the hours/minutes/seconds timer core.
package rtc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   // Never narrower than one bit so a counter always exists.
   function automatic int presc_w(input int div);
      return (div < 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/rtc_hms_timer_if.sv
// Control and time-of-day bundle for rtc_hms_timer.
// RTC_HMS_ALARM_EN adds the alarm compare inputs and the alarm pulse.
interface rtc_hms_timer_if #(
   parameter int HOUR_W = 5
);
   logic              start;
   logic              stop;
   logic              mode;
   logic              load;
   logic [HOUR_W-1:0] load_hh;
   logic [5:0]        load_mm;
   logic [5:0]        load_ss;
   logic [HOUR_W-1:0] hh;
   logic [5:0]        mm;
   logic [5:0]        ss;
   logic              tick;
   logic              running;
   logic              done;
   logic              wrap;
`ifdef RTC_HMS_ALARM_EN
   logic              alarm_en;
   logic [HOUR_W-1:0] alarm_hh;
   logic [5:0]        alarm_mm;
   logic [5:0]        alarm_ss;
   logic              alarm;

   modport master (
      output start, stop, mode, load, load_hh, load_mm, load_ss,
      output alarm_en, alarm_hh, alarm_mm, alarm_ss,
      input  hh, mm, ss, tick, running, done, wrap, alarm
   );
   modport slave (
      input  start, stop, mode, load, load_hh, load_mm, load_ss,
      input  alarm_en, alarm_hh, alarm_mm, alarm_ss,
      output hh, mm, ss, tick, running, done, wrap, alarm
   );
`else
   modport master (
      output start, stop, mode, load, load_hh, load_mm, load_ss,
      input  hh, mm, ss, tick, running, done, wrap
   );
   modport slave (
      input  start, stop, mode, load, load_hh, load_mm, load_ss,
      output hh, mm, ss, tick, running, done, wrap
   );
`endif
endinterface

// File: rtl/rtc_hms_timer_prescaler.sv
// Free-running divide-by-DIV counter; o_tc marks the last count while enabled.
module rtc_prescaler
   import rtc_pkg::*;
#(
   parameter int DIV = 2
)(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tc
);
   localparam int W = presc_w(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] r_cnt;
   logic         w_last;

   assign w_last = (r_cnt == LAST);
   assign o_tc   = i_en && w_last;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_last ? '0 : r_cnt + W'(1);
      end
   end
endmodule

// File: rtl/rtc_hms_timer.sv
// Hours/minutes/seconds clock and countdown timer with start/stop/load control.
// Optional alarm compare is built when RTC_HMS_ALARM_EN is defined.
module rtc_hms_timer
   import rtc_pkg::*;
#(
   parameter int CLK_HZ    = 125000000,
   parameter int TICK_HZ   = 1,
   parameter int MAX_HOURS = 24,
   parameter int HOUR_W    = 5
)(
   input logic             clk_125MHz,
   input logic             rst,
   rtc_hms_timer_if.slave  bus
);
   localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
   localparam logic [HOUR_W-1:0] HH_LAST = HOUR_W'(MAX_HOURS - 1);
   localparam logic [5:0]        SS_LAST = 6'(SEC_MAX);
   localparam logic [5:0]        MM_LAST = 6'(MIN_MAX);

   state_t            r_state;
   logic              r_mode;
   logic [HOUR_W-1:0] r_hh;
   logic [5:0]        r_mm;
   logic [5:0]        r_ss;
   logic              r_running;
   logic              r_done;
   logic              r_wrap;

   logic [HOUR_W-1:0] w_nx_hh;
   logic [5:0]        w_nx_mm;
   logic [5:0]        w_nx_ss;
   logic              w_up_wrap;
   logic              w_zero;
   logic              w_nx_zero;
   logic              w_zero_hold;
   logic              w_en;
   logic              w_tick;
   logic [HOUR_W-1:0] w_ld_hh;
   logic [5:0]        w_ld_mm;
   logic [5:0]        w_ld_ss;

   assign w_ld_hh = (bus.load_hh > HH_LAST) ? HH_LAST : bus.load_hh;
   assign w_ld_mm = (bus.load_mm > MM_LAST) ? MM_LAST : bus.load_mm;
   assign w_ld_ss = (bus.load_ss > SS_LAST) ? SS_LAST : bus.load_ss;

   // Time after one tick in the latched direction.
   always_comb begin
      w_nx_hh   = r_hh;
      w_nx_mm   = r_mm;
      w_nx_ss   = r_ss;
      w_up_wrap = 1'b0;
      if (!r_mode) begin
         if (r_ss == SS_LAST) begin
            w_nx_ss = '0;
            if (r_mm == MM_LAST) begin
               w_nx_mm = '0;
               if (r_hh == HH_LAST) begin
                  w_nx_hh   = '0;
                  w_up_wrap = 1'b1;
               end else begin
                  w_nx_hh = r_hh + HOUR_W'(1);
               end
            end else begin
               w_nx_mm = r_mm + 6'd1;
            end
         end else begin
            w_nx_ss = r_ss + 6'd1;
         end
      end else begin
         if (r_ss == 6'd0) begin
            w_nx_ss = SS_LAST;
            if (r_mm == 6'd0) begin
               w_nx_mm = MM_LAST;
               w_nx_hh = r_hh - HOUR_W'(1);
            end else begin
               w_nx_mm = r_mm - 6'd1;
            end
         end else begin
            w_nx_ss = r_ss - 6'd1;
         end
      end
   end

   assign w_zero      = (r_hh == '0) && (r_mm == 6'd0) && (r_ss == 6'd0);
   assign w_nx_zero   = (w_nx_hh == '0) && (w_nx_mm == 6'd0) && (w_nx_ss == 6'd0);
   // A countdown started at zero finishes without ever ticking.
   assign w_zero_hold = r_mode && w_zero;
   assign w_en        = (r_state == RUN) && !w_zero_hold;

   rtc_prescaler #(
      .DIV (DIV)
   ) u_presc (
      .i_clk (clk_125MHz),
      .i_rst (rst),
      .i_en  (w_en),
      .i_clr (bus.load),
      .o_tc  (w_tick)
   );

`ifdef RTC_HMS_ALARM_EN
   logic r_alarm;
   logic w_alarm_hit;

   assign w_alarm_hit = bus.alarm_en && (w_nx_hh == bus.alarm_hh) &&
                        (w_nx_mm == bus.alarm_mm) && (w_nx_ss == bus.alarm_ss);

   always_ff @(posedge clk_125MHz) begin
      if (rst) begin
         r_alarm <= 1'b0;
      end else begin
         r_alarm <= !bus.load && w_tick && w_alarm_hit;
      end
   end

   assign bus.alarm = r_alarm;
`endif

   always_ff @(posedge clk_125MHz) begin
      if (rst) begin
         r_state   <= IDLE;
         r_mode    <= 1'b0;
         r_hh      <= '0;
         r_mm      <= '0;
         r_ss      <= '0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_wrap    <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (bus.load) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_hh      <= w_ld_hh;
            r_mm      <= w_ld_mm;
            r_ss      <= w_ld_ss;
         end else begin
            case (r_state)
               IDLE, PAUSE: begin
                  if (bus.start && !bus.stop) begin
                     r_state   <= RUN;
                     r_running <= 1'b1;
                     r_mode    <= bus.mode;
                  end
               end
               RUN: begin
                  if (w_tick) begin
                     r_hh   <= w_nx_hh;
                     r_mm   <= w_nx_mm;
                     r_ss   <= w_nx_ss;
                     r_wrap <= w_up_wrap;
                  end
                  // Reaching zero ends the countdown even if stop arrives together.
                  if (w_zero_hold || (w_tick && r_mode && w_nx_zero)) begin
                     r_state   <= DONE;
                     r_running <= 1'b0;
                     r_done    <= 1'b1;
                  end else if (bus.stop) begin
                     r_state   <= PAUSE;
                     r_running <= 1'b0;
                  end
               end
               DONE: begin
                  r_state <= DONE;
               end
               default: begin
                  r_state   <= IDLE;
                  r_running <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.hh      = r_hh;
   assign bus.mm      = r_mm;
   assign bus.ss      = r_ss;
   assign bus.tick    = w_tick;
   assign bus.running = r_running;
   assign bus.done    = r_done;
   assign bus.wrap    = r_wrap;
endmodule
